// File: rtl/line_clear_engine_if.sv
// Board handshake between the game datapath and the line-clear engine.
// The datapath holds the master modport and the engine holds the slave modport.
interface line_clear_engine_if #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int CELL_W  = 4,
  parameter int SCORE_W = 14
);
  localparam int BOARD_W = ROWS * COLS * CELL_W;
  localparam int LC_W    = $clog2(ROWS + 1);

  logic               start;
  logic [BOARD_W-1:0] board_in;
  logic [BOARD_W-1:0] board_out;
  logic               busy;
  logic               done;
  logic [LC_W-1:0]    lines_cleared;
  logic [SCORE_W-1:0] score;
  logic               top_occupied;

  modport master (
    output start, board_in,
    input  board_out, busy, done, lines_cleared, score, top_occupied
  );

  modport slave (
    input  start, board_in,
    output board_out, busy, done, lines_cleared, score, top_occupied
  );
endinterface

// File: rtl/line_clear_engine.sv
// Removes full rows bottom-up, compacts the survivors and keeps a saturating score.
// Latency ROWS+N+1 edges from the start edge; start is dropped while busy (no queueing).
// LINE_SCORE_TABLE_EN selects the 0/1/3/5/8 score table instead of one point per line.
module line_clear_engine #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int CELL_W  = 4,
  parameter int SCORE_W = 14
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               game_reset,
  line_clear_engine_if.slave bus
);
  localparam int ROW_W   = COLS * CELL_W;
  localparam int BOARD_W = ROWS * ROW_W;
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = $clog2(ROWS + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam int unsigned SCORE_MAX = (2 ** SCORE_W) - 1;

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   work [ROWS];
  logic [RW-1:0]      rd, wr;
  logic [CW-1:0]      cnt;
  logic               row_full;
  logic               clr;
  logic [BOARD_W-1:0] board_q;
  logic [CW-1:0]      lines_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_nxt;
  logic               done_q;
  logic               top_q;

  assign clr = Reset | game_reset;

  function automatic logic [SCORE_W:0] score_inc(input logic [CW-1:0] n);
    int unsigned nn;
    int unsigned v;
    nn = 32'(n);
`ifdef LINE_SCORE_TABLE_EN
    if (nn == 0)      v = 0;
    else if (nn == 1) v = 1;
    else if (nn == 2) v = 3;
    else if (nn == 3) v = 5;
    else              v = 8 + 3 * (nn - 4);
`else
    v = nn;
`endif
    // Pre-clamping keeps the SCORE_W+1 bit sum from wrapping on huge boards.
    if (v > SCORE_MAX) v = SCORE_MAX;
    return (SCORE_W + 1)'(v);
  endfunction

  always_comb begin
    score_sum = {1'b0, score_q} + score_inc(cnt);
    score_nxt = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (work[rd][c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (rd == '0) state_nxt = (row_full || cnt != '0) ? FILL : DONE;
      FILL:    if (wr == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      board_q <= '0;
      lines_q <= '0;
      score_q <= '0;
      done_q  <= 1'b0;
      top_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int r = 0; r < ROWS; r++) work[r] <= bus.board_in[r*ROW_W +: ROW_W];
            rd  <= LAST_ROW;
            wr  <= LAST_ROW;
            cnt <= '0;
          end
        end
        SCAN: begin
          // wr never drops below rd, so this copy cannot clobber an unread row.
          if (row_full) begin
            cnt <= cnt + 1'b1;
          end else begin
            work[wr] <= work[rd];
            wr       <= wr - 1'b1;
          end
          if (rd != '0) rd <= rd - 1'b1;
        end
        FILL: begin
          work[wr] <= '0;
          wr       <= wr - 1'b1;
        end
        DONE: begin
          for (int r = 0; r < ROWS; r++) board_q[r*ROW_W +: ROW_W] <= work[r];
          lines_q <= cnt;
          score_q <= score_nxt;
          top_q   <= |work[0];
          done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_q;
  assign bus.board_out     = board_q;
  assign bus.lines_cleared = lines_q;
  assign bus.score         = score_q;
  assign bus.top_occupied  = top_q;
endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench: main 20x10 engine plus a SCORE_W=4 instance for saturation.
module tb_line_clear_engine;
  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int CELL_W = 4;
  localparam int ROW_W  = COLS * CELL_W;
  localparam int BW     = ROWS * ROW_W;

  logic Clk = 1'b0;
  logic Reset;
  logic game_reset;
  logic sat_game_reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_score = 0;

  always #5 Clk = ~Clk;

  line_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .SCORE_W(14)) bus ();
  line_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .SCORE_W(4))  sbus ();

  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .SCORE_W(14)) u_dut (
    .Clk(Clk), .Reset(Reset), .game_reset(game_reset), .bus(bus)
  );
  line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .SCORE_W(4)) u_sat (
    .Clk(Clk), .Reset(Reset), .game_reset(sat_game_reset), .bus(sbus)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_inc(input int n);
`ifdef LINE_SCORE_TABLE_EN
    if (n == 0) return 0;
    if (n == 1) return 1;
    if (n == 2) return 3;
    if (n == 3) return 5;
    return 8 + 3 * (n - 4);
`else
    return n;
`endif
  endfunction

  function automatic logic [BW-1:0] put_row(input logic [BW-1:0] b, input int r,
                                            input logic [ROW_W-1:0] v);
    b[r*ROW_W +: ROW_W] = v;
    return b;
  endfunction

  // One operation on the main engine; n is the expected number of cleared rows.
  task automatic do_op(input string name, input logic [BW-1:0] b, input logic [BW-1:0] eb,
                       input int n, input logic etop);
    int lat;
    int e;
    @(negedge Clk);
    bus.start    = 1'b1;
    bus.board_in = b;
    @(negedge Clk);
    bus.start = 1'b0;
    chk({name, "_busy_rise"}, BW'(bus.busy), BW'(1));
    lat = -1;
    e   = 0;
    while (lat < 0 && e < 2 * ROWS + 8) begin
      @(negedge Clk);
      e++;
      if (bus.done) lat = e;
    end
    exp_score += exp_inc(n);
    chk({name, "_latency"}, BW'(lat), BW'(ROWS + n + 1));
    chk({name, "_busy_fall"}, BW'(bus.busy), BW'(0));
    chk({name, "_lines"}, BW'(bus.lines_cleared), BW'(n));
    chk({name, "_board"}, bus.board_out, eb);
    chk({name, "_top"}, BW'(bus.top_occupied), BW'(etop));
    chk({name, "_score"}, BW'(bus.score), BW'(exp_score));
    @(negedge Clk);
    chk({name, "_done_pulse"}, BW'(bus.done), BW'(0));
  endtask

  initial begin
    logic [BW-1:0] b, eb, b3, b5, bfull;
    logic [ROW_W-1:0] fullrow, pat_a, pat_b;
    int dones;
    int s_exp;
    int got;

    Reset = 1'b1;
    game_reset = 1'b0;
    sat_game_reset = 1'b0;
    bus.start = 1'b0;
    bus.board_in = '0;
    sbus.start = 1'b0;
    sbus.board_in = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    chk("rst_busy", BW'(bus.busy), BW'(0));
    chk("rst_done", BW'(bus.done), BW'(0));
    chk("rst_board", bus.board_out, BW'(0));
    chk("rst_lines", BW'(bus.lines_cleared), BW'(0));
    chk("rst_score", BW'(bus.score), BW'(0));
    chk("rst_top", BW'(bus.top_occupied), BW'(0));

    fullrow = 40'h3333333333;
    pat_a   = 40'h00000000C7;
    pat_b   = 40'h9000000030;
    bfull   = '1;

    do_op("empty", '0, '0, 0, 1'b0);

    b  = put_row(put_row('0, 19, fullrow), 18, 40'h0000002222);
    eb = put_row('0, 19, 40'h0000002222);
    do_op("one_line", b, eb, 1, 1'b0);

    b3 = '0;
    for (int r = 16; r < 20; r++) b3 = put_row(b3, r, fullrow);
    b3 = put_row(b3, 15, 40'h0000000005);
    eb = put_row('0, 19, 40'h0000000005);
    do_op("four_lines", b3, eb, 4, 1'b0);

    b  = put_row(put_row(put_row(put_row('0, 19, fullrow), 18, pat_a), 17, 40'hABCDEF1234), 16, pat_b);
    eb = put_row(put_row('0, 19, pat_a), 18, pat_b);
    do_op("gap_clear", b, eb, 2, 1'b0);

    do_op("full_board", bfull, '0, ROWS, 1'b0);

    // One empty cell keeps a row; row 0 occupancy raises the game-over hint.
    b5 = put_row(put_row('0, 19, 40'h1111111110), 0, 40'h7000000000);
    do_op("no_clear_top", b5, b5, 0, 1'b1);

    @(negedge Clk);
    bus.start = 1'b1;
    bus.board_in = b5;
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (5) @(negedge Clk);
    bus.start = 1'b1;
    bus.board_in = bfull;
    @(negedge Clk);
    bus.start = 1'b0;
    bus.board_in = '0;
    dones = 0;
    repeat (60) begin
      @(negedge Clk);
      if (bus.done) dones++;
    end
    chk("busy_start_dones", BW'(dones), BW'(1));
    chk("busy_start_board", bus.board_out, b5);
    chk("busy_start_lines", BW'(bus.lines_cleared), BW'(0));
    chk("busy_start_score", BW'(bus.score), BW'(exp_score));

    @(negedge Clk);
    bus.start = 1'b1;
    bus.board_in = b3;
    @(negedge Clk);
    bus.start = 1'b0;
    repeat (10) @(negedge Clk);
    game_reset = 1'b1;
    @(negedge Clk);
    game_reset = 1'b0;
    exp_score = 0;
    chk("abort_busy", BW'(bus.busy), BW'(0));
    chk("abort_score", BW'(bus.score), BW'(0));
    chk("abort_board", bus.board_out, BW'(0));
    chk("abort_lines", BW'(bus.lines_cleared), BW'(0));
    chk("abort_top", BW'(bus.top_occupied), BW'(0));
    dones = 0;
    repeat (45) begin
      @(negedge Clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", BW'(dones), BW'(0));

    @(negedge Clk);
    Reset = 1'b1;
    bus.start = 1'b1;
    bus.board_in = bfull;
    @(negedge Clk);
    Reset = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", BW'(bus.busy), BW'(0));
    dones = 0;
    repeat (45) begin
      @(negedge Clk);
      if (bus.done) dones++;
    end
    chk("rst_start_no_done", BW'(dones), BW'(0));

    do_op("after_reset", b3, put_row('0, 19, 40'h0000000005), 4, 1'b0);

    s_exp = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      sbus.start = 1'b1;
      sbus.board_in = b3;
      @(negedge Clk);
      sbus.start = 1'b0;
      got = 0;
      for (int e = 0; e < 60 && got == 0; e++) begin
        @(negedge Clk);
        if (sbus.done) got = 1;
      end
      s_exp = (s_exp + exp_inc(4) > 15) ? 15 : s_exp + exp_inc(4);
      chk("sat_done", BW'(got), BW'(1));
      chk("sat_score", BW'(sbus.score), BW'(s_exp));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/line_clear_engine.md
# line_clear_engine

Parametrised multi-cycle line-clear and compaction engine for the falling-block game board. After the piece-load step, the datapath hands it a snapshot of the pixel map. The engine scans the rows bottom-up, removes every full row and shifts the surviving rows down. It returns the compacted board with a cleared-line count and a running score, replacing the fixed 20x10 single-shot clear path with one generalised in board size, cell width and scoring mode.

## Interface
Parameters:
- ROWS, 20, board height; row 0 is top, row ROWS-1 is bottom
- COLS, 10, board width
- CELL_W, 4, bits per cell; value 0 = empty, nonzero = occupied
- SCORE_W, 14, score register width

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- game_reset  in  1  synchronous active-high new-game clear (same effect as Reset)
- start  in  1  request to process board_in; sampled only in IDLE
- board_in  in  ROWS*COLS*CELL_W  board snapshot; cell (r,c) at bits [(r*COLS+c)*CELL_W +: CELL_W]
- board_out  out  ROWS*COLS*CELL_W  compacted board, same packing
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; board_out, lines_cleared and score are valid from this cycle on
- lines_cleared  out  $clog2(ROWS+1)  number of rows removed by the last operation
- score  out  SCORE_W  accumulated score, saturating
- top_occupied  out  1  row 0 of board_out has at least one nonzero cell (game-over hint)

## Operation
- States: IDLE, SCAN, FILL, DONE.
- IDLE with start=1:
  - latch board_in into the working register
  - rd <= ROWS-1, wr <= ROWS-1, cnt <= 0
  - go to SCAN
- IDLE with start=0: no change.
- SCAN, one row per cycle:
  - Row full = every cell in row rd is nonzero.
  - Full row: cnt <= cnt+1, wr unchanged.
  - Otherwise: work[wr] <= work[rd], wr <= wr-1. A copy with wr==rd is legal.
  - rd <= rd-1.
  - After row 0 is processed: go to FILL if cnt (including this row) > 0, else go to DONE.
- In-place safety: wr >= rd always holds, so no unread row is ever overwritten.
- FILL:
  - work[wr] <= 0, wr <= wr-1, once per cycle.
  - Runs exactly cnt cycles, then goes to DONE.
- DONE, one cycle:
  - board_out <= work, lines_cleared <= cnt, score updated.
  - top_occupied recomputed from the new board_out.
  - done=1; next state IDLE.
- board_out, lines_cleared, score and top_occupied hold their values between operations.
- start while busy: ignored, no queueing.
- Score arithmetic: add in SCORE_W+1 bits; a result above 2^SCORE_W-1 clamps to 2^SCORE_W-1. cnt=0 adds 0.
- Full board (all rows full): cnt=ROWS, FILL runs ROWS cycles, board_out all zero.

## Timing
- Start sampled at clock edge 0 → done is high in the cycle following edge ROWS+N+1, where N = rows cleared.
  - N=0: latency ROWS+1 edges.
  - Maximum latency: 2*ROWS+1 edges.
- busy rises the cycle after start is sampled and falls together with done.
- The earliest new start is the cycle after done; back-to-back operations are accepted.
- Reset or game_reset, taking priority over everything, at any edge:
  - state <= IDLE; any in-progress operation is aborted
  - board_out <= 0, lines_cleared <= 0, score <= 0
  - busy = 0, done = 0, top_occupied = 0
- start sampled in the same cycle as a reset is dropped.

## Configuration
- LINE_SCORE_TABLE_EN defined:
  - score increment per operation = 0/1/3/5/8 for N = 0/1/2/3/4.
  - N > 4 uses 8 + 3*(N-4).
- LINE_SCORE_TABLE_EN undefined: increment = N (one point per line).

## Test plan
- Empty board, start → done at edge 21 (ROWS=20); lines_cleared=0; board_out all zero; score unchanged; top_occupied=0.
- Row 19 full, row 18 cells c0..c3 = 4'h2, rest empty, start:
  - done at edge 22; lines_cleared=1
  - board_out row 19 = old row 18; row 18 = 0
  - score +1 (+1 with table)
- Rows 16..19 full, row 15 = 4'h5 at c0, start:
  - done at edge 25; lines_cleared=4; old row 15 now in row 19
  - score +4 without table, +8 with LINE_SCORE_TABLE_EN
- Non-contiguous clear:
  - Rows 19 and 17 full; rows 18 and 16 partial, distinct patterns A and B.
  - Required: row 19 = A, row 18 = B, rows 16..17 = 0, lines_cleared=2, done at edge 23.
- Score saturation: SCORE_W=4, repeated 4-line clears without table → score 4, 8, 12, 15, 15.
- Abort and busy-start:
  - Assert game_reset at SCAN cycle 10 → next cycle busy=0, score=0, board_out=0, no done pulse.
  - A start pulsed while busy is ignored: exactly one done per accepted start.
